load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 CLK  input  1  single clock, all state on rising edge.
REQ-002 RSTn  input  1  asynchronous active-low reset.
REQ-003 req_valid  input  1  MEM-stage access request, qualified by MemRead/MemWrite.
REQ-004 MemRead  input  1  load request from decode control.
REQ-005 MemWrite  input  1  store request from decode control.
REQ-006 funct3  input  3  load/store width and signedness (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-007 BE  input  4  unshifted byte enable from control (0001/0011/1111).
REQ-008 addr  input  32  byte address from ALU.
REQ-009 wdata  input  32  store data (rs2), LSB-justified.
REQ-010 stall  output  1  hold pipeline while access outstanding.
REQ-011 rdata  output  32  aligned, extended load result.
REQ-012 rdata_valid  output  1  one-cycle strobe, rdata valid.
REQ-013 err  output  1  one-cycle error strobe.
REQ-014 err_code  output  2  01 misaligned, 10 timeout, 11 illegal (MemRead and MemWrite both set).
REQ-015 mem_req, mem_we  output  1 each  memory strobe, write select.
REQ-016 mem_be  output  4  lane-shifted byte enable.
REQ-017 mem_addr  output  32  word address, bits [1:0] forced 0.
REQ-018 mem_wdata  output  32  lane-replicated store data.
REQ-019 mem_rdata  input  32  memory read word.
REQ-020 mem_ack  input  1  memory completion, valid only while mem_req=1.

Function
REQ-021 The FSM SHALL have states IDLE, ACCESS and DONE.
REQ-022 In IDLE with req_valid and exactly one of MemRead/MemWrite set and the address aligned, the unit SHALL latch addr/wdata/funct3/BE/direction, assert stall combinationally, and enter ACCESS.
REQ-023 Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00; byte is always aligned.
REQ-024 A misaligned or illegal request in IDLE SHALL pulse err the next cycle with the matching code, stay in IDLE, issue no memory access, and never assert stall.
REQ-025 req_valid with both MemRead and MemWrite low SHALL be ignored.
REQ-026 In ACCESS, mem_req SHALL be 1 and mem_be/mem_addr/mem_we/mem_wdata SHALL be stable, and stall SHALL be 1.
REQ-027 mem_be SHALL equal latched BE shifted left by addr[1:0].
REQ-028 Store data replication: SB puts wdata[7:0] on all four lanes, SH puts wdata[15:0] on both halves, SW passes wdata through.
REQ-029 On mem_ack in ACCESS, a load SHALL register rdata = (mem_rdata >> 8*addr[1:0]), sign-extended from bit 7 (LB) or bit 15 (LH), zero-extended for LBU/LHU, unchanged for LW; the FSM SHALL then go to DONE.
REQ-030 In DONE, stall SHALL be 0 and rdata_valid SHALL be 1 for loads only; the FSM SHALL return to IDLE next cycle, so minimum latency is 2 cycles from acceptance to release.
REQ-031 A 4-bit wait counter SHALL clear on ACCESS entry and increment each ACCESS cycle without ack; with no ack after 16 cycles it SHALL pulse err with code 10, drop mem_req, and go to IDLE with stall=0.
REQ-032 If ack arrives on the 16th cycle, ack SHALL win and no timeout SHALL be flagged.
REQ-033 req_valid during ACCESS/DONE SHALL be ignored; the pipeline holds it via stall.
REQ-034 rdata SHALL hold its last value until the next load completes.

Reset
REQ-035 On RSTn=0, the unit SHALL go to IDLE immediately, mid-access included, with mem_req, mem_we, stall, rdata_valid and err = 0, mem_be = 0, rdata = 0, err_code = 00, counter = 0.
REQ-036 An access aborted by reset SHALL NOT be reissued.

Structure
REQ-037 Package lsu_pkg SHALL hold the state enum, funct3 width encodings, err_code constants, and TIMEOUT=16.
REQ-038 Lane alignment, replication and extension SHALL live in the combinational sub-module lsu_align; the FSM, counter and registers SHALL live in load_store_unit.

Verification
REQ-039 LW addr=0x100, ack after 1 cycle, mem_rdata=0xDEADBEEF -> mem_be=1111, mem_addr=0x100, rdata=0xDEADBEEF, rdata_valid 1 cycle.
REQ-040 LB addr=0x103, mem_rdata=0x80xxxxxx -> mem_be=1000, rdata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-041 SH addr=0x102, wdata=0x1234ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD.
REQ-042 LW addr=0x101 -> err=1, err_code=01, mem_req never asserted, stall=0.
REQ-043 Load with no ack -> err_code=10 after 16 ACCESS cycles, mem_req drops; ack on the 16th cycle gives a normal completion instead.
REQ-044 RSTn low during ACCESS -> mem_req and stall drop in the same cycle; the FSM is in IDLE when reset releases.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access-width
// encodings, error codes and the memory wait limit.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // funct3[1:0] carries the access size for both loads and stores
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    localparam int         TIMEOUT  = 16;
    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            SZ_BYTE: is_aligned = 1'b1;
            SZ_HALF: is_aligned = ~off[0];
            default: is_aligned = (off == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Pipeline-side request/response and memory-side strobes of the load/store unit.
// The LSU uses the slave modport; the pipeline/memory environment uses master.
interface lsu_if;
    logic        req_valid;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [3:0]  BE;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        err;
    logic [1:0]  err_code;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  req_valid, MemRead, MemWrite, funct3, BE, addr, wdata, mem_rdata, mem_ack,
        output stall, rdata, rdata_valid, err, err_code,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, MemRead, MemWrite, funct3, BE, addr, wdata, mem_rdata, mem_ack,
        input  stall, rdata, rdata_valid, err, err_code,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: shifts byte enables into lane position,
// replicates store data across lanes and aligns/extends load data.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    always_comb begin
        mem_be = be << offset;

        case (funct3[1:0])
            SZ_BYTE: mem_wdata = {4{wdata[7:0]}};
            SZ_HALF: mem_wdata = {2{wdata[15:0]}};
            default: mem_wdata = wdata;
        endcase

        shifted = mem_rdata >> {offset, 3'b000};

        case (funct3)
            F3_LB:   rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  rdata = {24'h000000, shifted[7:0]};
            F3_LHU:  rdata = {16'h0000, shifted[15:0]};
            default: rdata = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: accepts one aligned access, drives a single
// memory transaction with ack timeout, and returns aligned load data.
//
//   state     | meaning
//   ST_IDLE   | waiting for a request; bad requests flagged via err
//   ST_ACCESS | mem_req held, waiting for mem_ack or timeout
//   ST_DONE   | one release cycle, rdata_valid strobes for loads
module load_store_unit
    import lsu_pkg::*;
(
    input  logic  CLK,
    input  logic  RSTn,
    lsu_if.slave  bus
);

    lsu_state_t  state;
    logic [3:0]  wait_cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;
    logic [3:0]  be_q;
    logic        we_q;

    logic [31:0] rdata_q;
    logic        rdata_valid_q;
    logic        err_q;
    logic [1:0]  err_code_q;

    logic [3:0]  be_lane;
    logic [31:0] wdata_rep;
    logic [31:0] rdata_ext;
    logic        one_dir;
    logic        accept;

    assign one_dir = bus.MemRead ^ bus.MemWrite;
    assign accept  = (state == ST_IDLE) && bus.req_valid && one_dir
                     && is_aligned(bus.funct3, bus.addr[1:0]);

    lsu_align u_align (
        .funct3    (funct3_q),
        .offset    (addr_q[1:0]),
        .be        (be_q),
        .wdata     (wdata_q),
        .mem_rdata (bus.mem_rdata),
        .mem_be    (be_lane),
        .mem_wdata (wdata_rep),
        .rdata     (rdata_ext)
    );

    // stall rises in the accepting cycle so the pipeline never sees a gap
    assign bus.stall     = accept || (state == ST_ACCESS);
    assign bus.mem_req   = (state == ST_ACCESS);
    assign bus.mem_we    = (state == ST_ACCESS) && we_q;
    assign bus.mem_be    = (state == ST_ACCESS) ? be_lane : 4'b0000;
    assign bus.mem_addr  = {addr_q[31:2], 2'b00};
    assign bus.mem_wdata = wdata_rep;

    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.err         = err_q;
    assign bus.err_code    = err_code_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state         <= ST_IDLE;
            wait_cnt      <= 4'd0;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            funct3_q      <= 3'd0;
            be_q          <= 4'd0;
            we_q          <= 1'b0;
            rdata_q       <= 32'd0;
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= ERR_NONE;
        end else begin
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        if (bus.MemRead && bus.MemWrite) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_ILLEGAL;
                        end else if (one_dir) begin
                            if (!is_aligned(bus.funct3, bus.addr[1:0])) begin
                                err_q      <= 1'b1;
                                err_code_q <= ERR_MISALIGN;
                            end else begin
                                addr_q   <= bus.addr;
                                wdata_q  <= bus.wdata;
                                funct3_q <= bus.funct3;
                                be_q     <= bus.BE;
                                we_q     <= bus.MemWrite;
                                wait_cnt <= 4'd0;
                                state    <= ST_ACCESS;
                            end
                        end
                    end
                end

                ST_ACCESS: begin
                    // ack on the final wait cycle still completes normally
                    if (bus.mem_ack) begin
                        if (!we_q) begin
                            rdata_q       <= rdata_ext;
                            rdata_valid_q <= 1'b1;
                        end
                        state <= ST_DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_TIMEOUT;
                        state      <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end

                ST_DONE: state <= ST_IDLE;

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stimulus pushes expected memory accesses
// and responses into queues; negedge monitors pop and compare.
module tb_load_store_unit;
    import lsu_pkg::*;

    typedef struct {
        logic [3:0]  be;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic        is_err;
        logic [1:0]  code;
        logic [31:0] data;
    } rsp_exp_t;

    logic CLK;
    logic RSTn;
    lsu_if u_if();

    load_store_unit dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (u_if)
    );

    mem_exp_t exp_mem[$];
    rsp_exp_t exp_rsp[$];
    int n_checks = 0;
    int n_fail   = 0;
    logic mem_req_prev = 1'b0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // memory-side monitor: every ACCESS cycle must present the expected, stable access
    always @(negedge CLK) begin
        if (u_if.mem_req) begin
            n_checks++;
            if (exp_mem.size() == 0) begin
                n_fail++;
                $display("FAIL mem_unexpected: got mem_req addr=%h be=%b, want no access",
                         u_if.mem_addr, u_if.mem_be);
            end else if (u_if.mem_be !== exp_mem[0].be || u_if.mem_addr !== exp_mem[0].addr ||
                         u_if.mem_we !== exp_mem[0].we || u_if.mem_wdata !== exp_mem[0].wdata) begin
                n_fail++;
                $display("FAIL mem_access: got be=%b addr=%h we=%b wdata=%h want be=%b addr=%h we=%b wdata=%h",
                         u_if.mem_be, u_if.mem_addr, u_if.mem_we, u_if.mem_wdata,
                         exp_mem[0].be, exp_mem[0].addr, exp_mem[0].we, exp_mem[0].wdata);
            end
        end else if (mem_req_prev && exp_mem.size() != 0) begin
            void'(exp_mem.pop_front());
        end
        mem_req_prev = u_if.mem_req;
    end

    // response monitor: rdata_valid and err strobes
    always @(negedge CLK) begin
        if (u_if.rdata_valid || u_if.err) begin
            rsp_exp_t e;
            n_checks++;
            if (exp_rsp.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got rdata_valid=%b err=%b code=%b, want none",
                         u_if.rdata_valid, u_if.err, u_if.err_code);
            end else begin
                e = exp_rsp.pop_front();
                if (e.is_err) begin
                    if (!u_if.err || u_if.rdata_valid || u_if.err_code !== e.code) begin
                        n_fail++;
                        $display("FAIL rsp_err: got err=%b rdata_valid=%b code=%b want err=1 code=%b",
                                 u_if.err, u_if.rdata_valid, u_if.err_code, e.code);
                    end
                end else if (u_if.err || u_if.rdata !== e.data) begin
                    n_fail++;
                    $display("FAIL rsp_load: got err=%b rdata=%h want err=0 rdata=%h",
                             u_if.err, u_if.rdata, e.data);
                end
            end
        end
    end

    task automatic run_vec(
        input string       name,
        input logic        rd, input logic wr,
        input logic [2:0]  f3, input logic [3:0] be,
        input logic [31:0] a,  input logic [31:0] wd,
        input int          ack_cycle, input logic [31:0] mrd,
        input logic        mem_v, input logic [3:0] ebe,
        input logic [31:0] eaddr, input logic [31:0] ewd,
        input logic        rsp_v, input logic rerr, input logic [1:0] rcode,
        input logic [31:0] rdat,
        input int          exp_cycles, input logic noise);
        int cycles;
        @(negedge CLK);
        u_if.req_valid = 1'b1;
        u_if.MemRead   = rd;
        u_if.MemWrite  = wr;
        u_if.funct3    = f3;
        u_if.BE        = be;
        u_if.addr      = a;
        u_if.wdata     = wd;
        if (mem_v) exp_mem.push_back(mem_exp_t'{ebe, eaddr, wr, ewd});
        if (rsp_v) exp_rsp.push_back(rsp_exp_t'{rerr, rcode, rdat});
        #1;
        chk({name, "_stall_accept"}, 32'(u_if.stall), 32'(mem_v));
        @(posedge CLK);
        #1;
        if (noise) begin
            u_if.MemRead  = 1'b1;
            u_if.MemWrite = 1'b0;
            u_if.funct3   = F3_LW;
            u_if.addr     = 32'h0000_0554;
        end else begin
            u_if.req_valid = 1'b0;
        end
        cycles = 0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge CLK);
            if (!u_if.mem_req) break;
            cycles++;
            u_if.mem_ack   = (k == ack_cycle);
            u_if.mem_rdata = mrd;
        end
        u_if.mem_ack   = 1'b0;
        u_if.req_valid = 1'b0;
        #1;
        chk({name, "_access_cycles"}, 32'(cycles), 32'(exp_cycles));
        chk({name, "_stall_release"}, 32'(u_if.stall), 32'd0);
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int mreq_seen;
        RSTn           = 1'b0;
        u_if.req_valid = 1'b0;
        u_if.MemRead   = 1'b0;
        u_if.MemWrite  = 1'b0;
        u_if.funct3    = 3'd0;
        u_if.BE        = 4'd0;
        u_if.addr      = 32'd0;
        u_if.wdata     = 32'd0;
        u_if.mem_rdata = 32'd0;
        u_if.mem_ack   = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_outputs", 32'({u_if.stall, u_if.mem_req, u_if.mem_we, u_if.rdata_valid,
                                  u_if.err, u_if.err_code, u_if.mem_be}), 32'd0);
        chk("reset_rdata", u_if.rdata, 32'd0);
        RSTn = 1'b1;
        repeat (2) @(negedge CLK);

        run_vec("lw_100",  1, 0, F3_LW,  4'b1111, 32'h100, 32'h0, 1, 32'hDEADBEEF,
                1, 4'b1111, 32'h100, 32'h0, 1, 0, ERR_NONE, 32'hDEADBEEF, 1, 0);
        run_vec("lb_103",  1, 0, F3_LB,  4'b0001, 32'h103, 32'h0, 2, 32'h80123456,
                1, 4'b1000, 32'h100, 32'h0, 1, 0, ERR_NONE, 32'hFFFFFF80, 2, 1);
        run_vec("lbu_103", 1, 0, F3_LBU, 4'b0001, 32'h103, 32'h0, 1, 32'h80123456,
                1, 4'b1000, 32'h100, 32'h0, 1, 0, ERR_NONE, 32'h00000080, 1, 0);
        run_vec("sh_102",  0, 1, F3_SH,  4'b0011, 32'h102, 32'h1234ABCD, 1, 32'h0,
                1, 4'b1100, 32'h100, 32'hABCDABCD, 0, 0, ERR_NONE, 32'h0, 1, 0);
        chk("rdata_hold_after_store", u_if.rdata, 32'h00000080);
        run_vec("lw_101",  1, 0, F3_LW,  4'b1111, 32'h101, 32'h0, 0, 32'h0,
                0, 4'b0, 32'h0, 32'h0, 1, 1, ERR_MISALIGN, 32'h0, 0, 0);
        run_vec("lh_102",  1, 0, F3_LH,  4'b0011, 32'h102, 32'h0, 3, 32'h80011234,
                1, 4'b1100, 32'h100, 32'h0, 1, 0, ERR_NONE, 32'hFFFF8001, 3, 0);
        run_vec("lhu_200", 1, 0, F3_LHU, 4'b0011, 32'h200, 32'h0, 1, 32'h8001F234,
                1, 4'b0011, 32'h200, 32'h0, 1, 0, ERR_NONE, 32'h0000F234, 1, 0);
        run_vec("sb_201",  0, 1, F3_SB,  4'b0001, 32'h201, 32'h123456A5, 2, 32'h0,
                1, 4'b0010, 32'h200, 32'hA5A5A5A5, 0, 0, ERR_NONE, 32'h0, 2, 0);
        run_vec("sw_204",  0, 1, F3_SW,  4'b1111, 32'h204, 32'hCAFEF00D, 1, 32'h0,
                1, 4'b1111, 32'h204, 32'hCAFEF00D, 0, 0, ERR_NONE, 32'h0, 1, 0);
        run_vec("lh_103",  1, 0, F3_LH,  4'b0011, 32'h103, 32'h0, 0, 32'h0,
                0, 4'b0, 32'h0, 32'h0, 1, 1, ERR_MISALIGN, 32'h0, 0, 0);
        run_vec("sw_202",  0, 1, F3_SW,  4'b1111, 32'h202, 32'h0, 0, 32'h0,
                0, 4'b0, 32'h0, 32'h0, 1, 1, ERR_MISALIGN, 32'h0, 0, 0);
        run_vec("illegal", 1, 1, F3_LW,  4'b1111, 32'h100, 32'h0, 0, 32'h0,
                0, 4'b0, 32'h0, 32'h0, 1, 1, ERR_ILLEGAL, 32'h0, 0, 0);
        run_vec("no_op",   0, 0, F3_LW,  4'b1111, 32'h100, 32'h0, 0, 32'h0,
                0, 4'b0, 32'h0, 32'h0, 0, 0, ERR_NONE, 32'h0, 0, 0);
        run_vec("lb_101",  1, 0, F3_LB,  4'b0001, 32'h101, 32'h0, 1, 32'h00007F00,
                1, 4'b0010, 32'h100, 32'h0, 1, 0, ERR_NONE, 32'h0000007F, 1, 0);
        run_vec("timeout", 1, 0, F3_LW,  4'b1111, 32'h300, 32'h0, 0, 32'h0,
                1, 4'b1111, 32'h300, 32'h0, 1, 1, ERR_TIMEOUT, 32'h0, 16, 0);
        run_vec("ack_16",  1, 0, F3_LW,  4'b1111, 32'h300, 32'h0, 16, 32'h11223344,
                1, 4'b1111, 32'h300, 32'h0, 1, 0, ERR_NONE, 32'h11223344, 16, 0);

        // reset in the middle of an access
        @(negedge CLK);
        u_if.req_valid = 1'b1;
        u_if.MemRead   = 1'b1;
        u_if.MemWrite  = 1'b0;
        u_if.funct3    = F3_LW;
        u_if.BE        = 4'b1111;
        u_if.addr      = 32'h400;
        exp_mem.push_back(mem_exp_t'{4'b1111, 32'h400, 1'b0, 32'h0});
        @(posedge CLK);
        #1 u_if.req_valid = 1'b0;
        repeat (3) @(negedge CLK);
        chk("pre_reset_mem_req", 32'(u_if.mem_req), 32'd1);
        #2 RSTn = 1'b0;
        #1;
        chk("reset_drops_req_stall", 32'({u_if.mem_req, u_if.stall}), 32'd0);
        chk("reset_clears_rdata", u_if.rdata, 32'd0);
        chk("reset_clears_err_code", 32'(u_if.err_code), 32'd0);
        @(negedge CLK);
        RSTn = 1'b1;
        mreq_seen = 0;
        repeat (6) begin
            @(negedge CLK);
            if (u_if.mem_req) mreq_seen++;
        end
        chk("no_reissue_after_reset", 32'(mreq_seen), 32'd0);

        // state must be IDLE after reset: a fresh load is accepted and completes
        run_vec("post_reset", 1, 0, F3_LBU, 4'b0001, 32'h402, 32'h0, 1, 32'h00AB0000,
                1, 4'b0100, 32'h400, 32'h0, 1, 0, ERR_NONE, 32'h000000AB, 1, 0);

        repeat (4) @(negedge CLK);
        chk("mem_queue_drained", 32'(exp_mem.size()), 32'd0);
        chk("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
